// File: rtl/rsa_modexp_unit.sv
// rsa_modexp_unit: C = P^E mod M using two bit-serial Montgomery multipliers.
// The square path produces the running power of P, the multiply path
// accumulates the result. Every phase is one load cycle followed by WIDTH+2
// iteration cycles, so the latency does not depend on the operand values.
module rsa_modexp_unit #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Const,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int DW = WIDTH + 2;                   // datapath width, R = 2^DW
  localparam int CW = $clog2(DW + 1);              // phase counter holds 0..DW
  localparam int IW = $clog2(DW);                  // bit index into a DW operand
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_LOOP = 3'd2,
    S_POST = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     k_q, k_d;
  logic [DW-1:0]        pm_q, pm_d;
  logic [DW-1:0]        rm_q, rm_d;
  logic [DW-1:0]        s_sq_q, s_sq_d;
  logic [DW-1:0]        s_mul_q, s_mul_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [DW-1:0]        a_sq_s, b_sq_s, a_mul_s, b_mul_s;
  logic [DW-1:0]        step_sq_s, step_mul_s;
  logic [DW-1:0]        diff_s;
  logic [IW-1:0]        idx_s;
  logic                 mul_en_s;

  // One Montgomery iteration: add a_bit*B, make the sum even with M, halve.
  function automatic logic [DW-1:0] mmm_step(input logic [DW-1:0]    s,
                                              input logic             a_bit,
                                              input logic [DW-1:0]    b,
                                              input logic [WIDTH-1:0] m);
    logic [DW:0] sum;
    sum = {1'b0, s} + (a_bit ? {1'b0, b} : {(DW+1){1'b0}});
    if (sum[0]) begin
      sum = sum + {3'b000, m};
    end else begin
      sum = sum;
    end
    return sum[DW:1];
  endfunction

  // Operand selection: PRE converts into the Montgomery domain, POST converts out.
  assign a_sq_s     = (state_q == S_PRE) ? {2'b00, k_q} : pm_q;
  assign b_sq_s     = (state_q == S_PRE) ? {2'b00, p_q} : pm_q;
  assign a_mul_s    = (state_q == S_PRE) ? {2'b00, k_q} : rm_q;
  assign b_mul_s    = ((state_q == S_PRE) || (state_q == S_POST)) ? {{(DW-1){1'b0}}, 1'b1} : pm_q;
  assign idx_s      = IW'(cyc_q - CW'(1));
  assign step_sq_s  = mmm_step(s_sq_q, a_sq_s[idx_s], b_sq_s, m_q);
  assign step_mul_s = mmm_step(s_mul_q, a_mul_s[idx_s], b_mul_s, m_q);
  assign mul_en_s   = (state_q == S_LOOP) ? e_q[bit_q] : 1'b1;
  assign diff_s     = rm_q - {2'b00, m_q};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    k_d     = k_q;
    pm_d    = pm_q;
    rm_d    = rm_q;
    s_sq_d  = s_sq_q;
    s_mul_d = s_mul_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          p_d     = P;
          e_d     = E;
          m_d     = M;
          k_d     = Const;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cyc_d   = '0;
          bit_d   = '0;
          // An even modulus skips straight to the completion stage.
          state_d = M[0] ? S_PRE : S_FIX;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PRE, S_LOOP, S_POST: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cyc_q == CW'(0)) begin
          s_sq_d  = '0;
          s_mul_d = '0;
          cyc_d   = CW'(1);
        end else begin
          s_sq_d  = step_sq_s;
          s_mul_d = step_mul_s;
          if (cyc_q == CW'(DW)) begin
            cyc_d = '0;
            if (state_q != S_POST) begin
              pm_d = step_sq_s;
            end else begin
              pm_d = pm_q;
            end
            if (mul_en_s) begin
              rm_d = step_mul_s;
            end else begin
              rm_d = rm_q;
            end
            if (state_q == S_PRE) begin
              state_d = S_LOOP;
            end else if (state_q == S_LOOP) begin
              if (bit_q == BW'(EXP_WIDTH - 1)) begin
                state_d = S_POST;
              end else begin
                bit_d = bit_q + BW'(1);
              end
            end else begin
              state_d = S_FIX;
            end
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
      end

      S_FIX: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
          if (!m_q[0]) begin
            c_d   = '0;
            err_d = 1'b1;
          end else if (rm_q >= {2'b00, m_q}) begin
            c_d = diff_s[WIDTH-1:0];
          end else begin
            c_d = rm_q[WIDTH-1:0];
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; everything holds while en is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      pm_q    <= '0;
      rm_q    <= '0;
      s_sq_q  <= '0;
      s_mul_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      k_q     <= k_d;
      pm_q    <= pm_d;
      rm_q    <= rm_d;
      s_sq_q  <= s_sq_d;
      s_mul_q <= s_mul_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed and randomized checks of rsa_modexp_unit at WIDTH=8, EXP_WIDTH=8.
module tb_rsa_modexp_unit;

  logic       clk;
  logic       rstb;
  logic       en;
  logic       start;
  logic       abort;
  logic [7:0] P;
  logic [7:0] E;
  logic [7:0] M;
  logic [7:0] Const;
  logic [7:0] C;
  logic       busy;
  logic       done;
  logic       err;

  int n_pass;
  int n_total;

  rsa_modexp_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .abort(abort),
    .P(P), .E(E), .M(M), .Const(Const),
    .C(C), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_start(input int p, input int e, input int m, input int k);
    P     = 8'(p);
    E     = 8'(e);
    M     = 8'(m);
    Const = 8'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded so the bench cannot hang.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  function automatic int ref_modpow(input int p, input int e, input int m);
    int r;
    int b;
    r = 1 % m;
    b = p % m;
    for (int i = 0; i < 8; i++) begin
      if (((e >> i) & 1) == 1) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  initial begin
    int lat;
    int lat2;
    int seen;
    int rp, re, rm, rk;
    n_pass  = 0;
    n_total = 0;
    rstb  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    P = 8'd0; E = 8'd0; M = 8'd0; Const = 8'd0;
    tick(); tick(); tick();
    check("reset_C", 32'(C), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rstb = 1'b1;
    tick();

    // 7^5 mod 11 = 10, exact latency
    do_start(7, 5, 11, 1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd111);
    check("t1_C", 32'(C), 32'd10);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2^8 mod 13 = 9, then back-to-back start in the done cycle
    do_start(2, 8, 13, 9);
    wait_done(lat);
    check("t2_C", 32'(C), 32'd9);
    do_start(7, 0, 11, 1);
    check("t3_busy_b2b", 32'(busy), 32'd1);
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'd111);
    check("t3_C_e0", 32'(C), 32'd1);
    do_start(7, 3, 1, 0);
    wait_done(lat);
    check("t4_C_m1", 32'(C), 32'd0);

    // Even modulus: error completion one cycle after accept
    tick();
    do_start(5, 3, 10, 0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_done_early", 32'(done), 32'd0);
    tick();
    check("t5_done", 32'(done), 32'd1);
    check("t5_err", 32'(err), 32'd1);
    check("t5_C", 32'(C), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    tick();
    check("t5_done_clear", 32'(done), 32'd0);
    check("t5_err_hold", 32'(err), 32'd1);

    // 3^4 mod 11 = 4, leaves a nonzero C for the abort test
    do_start(3, 4, 11, 1);
    wait_done(lat);
    check("t6_C", 32'(C), 32'd4);
    check("t6_err_cleared", 32'(err), 32'd0);
    tick();

    // Abort at cycle 40
    do_start(7, 5, 11, 1);
    for (int i = 0; i < 39; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_busy_abort", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (done) seen++;
      tick();
    end
    check("t7_no_done", 32'(seen), 32'd0);
    check("t7_C_kept", 32'(C), 32'd4);
    check("t7_err_kept", 32'(err), 32'd0);
    do_start(7, 5, 11, 1);
    wait_done(lat);
    check("t7_restart_C", 32'(C), 32'd10);
    tick();

    // en low on 17 scattered cycles
    do_start(2, 8, 13, 9);
    lat = 0;
    while (!done && lat < 400) begin
      en = !(lat < 85 && (lat % 5) == 4);
      tick();
      lat++;
    end
    en = 1'b1;
    check("t8_latency_en", 32'(lat), 32'd128);
    check("t8_C", 32'(C), 32'd9);
    tick();

    // Operand changes and extra starts while busy
    do_start(7, 5, 11, 1);
    for (int i = 0; i < 10; i++) tick();
    do_start(200, 255, 13, 9);
    for (int i = 0; i < 20; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat2);
    check("t9_latency", 32'(lat2 + 32), 32'd111);
    check("t9_C", 32'(C), 32'd10);
    tick();

    // Reset mid-operation
    do_start(2, 8, 13, 9);
    for (int i = 0; i < 50; i++) tick();
    rstb = 1'b0;
    #1;
    check("t10_C", 32'(C), 32'd0);
    check("t10_busy", 32'(busy), 32'd0);
    check("t10_done", 32'(done), 32'd0);
    check("t10_err", 32'(err), 32'd0);
    tick(); tick();
    rstb = 1'b1;
    tick();

    // Random odd moduli against a plain square-and-multiply model
    for (int n = 0; n < 500; n++) begin
      rm = $urandom_range(1, 255) | 1;
      rp = $urandom_range(0, 255);
      re = $urandom_range(0, 255);
      rk = (1 << 20) % rm;
      do_start(rp, re, rm, rk);
      wait_done(lat);
      check($sformatf("rand_%0d_P%0d_E%0d_M%0d", n, rp, re, rm), 32'(C), 32'(ref_modpow(rp, re, rm)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
